clk_cfg_apb_init: RTL and testbench

Boot-time APB initiator that programs the clock generator's configuration bus from a constant command table. It issues APB writes, polls status registers until a masked value matches, and inserts fixed delays, in that table order. It sits in the SoC control domain next to the clock generator and holds its APB master port until the sequence completes or fails. It is the requester for the clock generator's APB responder.

---
 rtl/clk_cfg_pkg.sv | 51 +++++
 rtl/clk_cfg_apb_if.sv | 82 ++++++++
 rtl/clk_cfg_apb_init.sv | 180 ++++++++++++++++++
 tb/tb_clk_cfg_apb_init.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_pkg
// Description : Command table types and FSM encodings for the clock-config
//               APB boot initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_cfg_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_POLL  = 2'd1,
        CMD_WAIT  = 2'd2
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_e;

    localparam cmd_t CMD_NOP = '{op: CMD_WAIT, addr: 32'h0, data: 32'h0, mask: 32'h0};

    function automatic cmd_t mk_cmd(cmd_op_e op, logic [31:0] addr,
                                    logic [31:0] data, logic [31:0] mask);
        cmd_t c;
        c.op   = op;
        c.addr = addr;
        c.data = data;
        c.mask = mask;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_cfg_apb_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_apb_if
// Description : APB SETUP/ACCESS handshake engine; captures a request and
//               holds address/data stable for the whole transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_cfg_apb_if
    import clk_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    input  logic                  i_req_write,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [31:0]           o_pwdata,
    output logic                  o_pwrite,
    output logic                  o_psel,
    output logic                  o_penable,
    input  logic [31:0]           i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    apb_phase_e            r_phase;
    apb_phase_e            w_phase_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]           r_pwdata;
    logic                  r_pwrite;
    logic                  w_xfer_done;

    assign w_xfer_done = (r_phase == PH_ACCESS) && i_pready;

    always_comb begin
        w_phase_nxt = r_phase;
        unique case (r_phase)
            PH_IDLE:   if (i_req_valid) w_phase_nxt = PH_SETUP;
            PH_SETUP:  w_phase_nxt = PH_ACCESS;
            PH_ACCESS: if (i_pready) w_phase_nxt = i_req_valid ? PH_SETUP : PH_IDLE;
            default:   w_phase_nxt = PH_IDLE;
        endcase
    end

    // Request fields are zeroed when the bus goes idle so APB outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= PH_IDLE;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            if (i_req_valid) begin
                r_paddr  <= i_req_addr;
                r_pwdata <= i_req_wdata;
                r_pwrite <= i_req_write;
            end else if (w_xfer_done) begin
                r_paddr  <= '0;
                r_pwdata <= '0;
                r_pwrite <= 1'b0;
            end
        end
    end

    assign o_psel    = (r_phase != PH_IDLE);
    assign o_penable = (r_phase == PH_ACCESS);
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_pwrite  = r_pwrite;
    assign o_done    = w_xfer_done;
    assign o_rdata   = i_prdata;
    assign o_err     = w_xfer_done & i_pslverr;

endmodule
`default_nettype wire

// File: rtl/clk_cfg_apb_init.sv
`default_nettype none
// ============================================================================
// Module      : clk_cfg_apb_init
// Description : Boot-time APB initiator walking a constant WRITE/POLL/WAIT
//               command table to program the clock generator.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_cfg_apb_init
    import clk_cfg_pkg::*;
#(
    parameter int                  APB_ADDR_WIDTH = 32,
    parameter int                  NUM_CMDS       = 8,
    parameter cmd_t [NUM_CMDS-1:0] CMD_TABLE      = {NUM_CMDS{CMD_NOP}},
    parameter int                  POLL_TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [7:0]                err_idx_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int         c_SEL_W    = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
    localparam int         c_PCNT_W   = $clog2(POLL_TIMEOUT + 1);
    localparam logic [7:0] c_LAST_IDX = 8'(NUM_CMDS - 1);

    state_e                r_state, w_state_nxt;
    logic [7:0]            r_idx, w_idx_nxt;
    logic [c_PCNT_W-1:0]   r_pcnt, w_pcnt_nxt, w_pcnt_inc;
    logic [31:0]           r_wcnt, w_wcnt_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [7:0]            r_err_idx, w_err_idx_nxt;
    logic [7:0]            w_idx_inc;
    cmd_t                  w_cur, w_next, w_req_cmd;
    logic                  w_launch, w_advance, w_match;
    logic                  w_req_valid, w_xfer_done, w_xfer_err;
    logic [31:0]           w_rdata;

    assign w_idx_inc  = r_idx + 8'd1;
    assign w_pcnt_inc = r_pcnt + c_PCNT_W'(1);
    assign w_cur      = CMD_TABLE[r_idx[c_SEL_W-1:0]];
    assign w_next     = CMD_TABLE[w_idx_inc[c_SEL_W-1:0]];
    assign w_match    = ((w_rdata ^ w_cur.data) & w_cur.mask) == 32'h0;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pcnt_nxt    = r_pcnt;
        w_wcnt_nxt    = r_wcnt;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;
        w_err_idx_nxt = r_err_idx;
        w_launch      = 1'b0;
        w_advance     = 1'b0;
        w_req_cmd     = w_cur;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    w_done_nxt    = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_err_idx_nxt = 8'd0;
                    w_idx_nxt     = 8'd0;
                    w_pcnt_nxt    = '0;
                    w_launch      = 1'b1;
                    w_req_cmd     = CMD_TABLE[0];
                end
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_xfer_done) begin
                    if (w_xfer_err) begin
                        w_state_nxt   = ST_ERROR;
                        w_err_nxt     = 1'b1;
                        w_err_idx_nxt = r_idx;
                    end else if (w_cur.op == CMD_POLL && !w_match) begin
                        if (w_pcnt_inc == c_PCNT_W'(POLL_TIMEOUT)) begin
                            w_state_nxt   = ST_ERROR;
                            w_err_nxt     = 1'b1;
                            w_err_idx_nxt = r_idx;
                        end else begin
                            w_pcnt_nxt = w_pcnt_inc;
                            w_launch   = 1'b1;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            // A count of 0 or 1 both expire after a single cycle.
            ST_WAIT: begin
                if (r_wcnt <= 32'd1) w_advance = 1'b1;
                else                 w_wcnt_nxt = r_wcnt - 32'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_advance) begin
            w_pcnt_nxt = '0;
            if (r_idx == c_LAST_IDX) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_idx_nxt = w_idx_inc;
                w_launch  = 1'b1;
                w_req_cmd = w_next;
            end
        end

        if (w_launch) begin
            if (w_req_cmd.op == CMD_WAIT) begin
                w_state_nxt = ST_WAIT;
                w_wcnt_nxt  = w_req_cmd.data;
            end else begin
                w_state_nxt = ST_SETUP;
            end
        end
    end

    assign w_req_valid = w_launch && (w_req_cmd.op != CMD_WAIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_idx     <= 8'd0;
            r_pcnt    <= '0;
            r_wcnt    <= 32'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_err_idx <= w_err_idx_nxt;
        end
    end

    clk_cfg_apb_if #(
        .ADDR_WIDTH (APB_ADDR_WIDTH)
    ) u_apb_if (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .i_req_valid (w_req_valid),
        .i_req_addr  (w_req_cmd.addr[APB_ADDR_WIDTH-1:0]),
        .i_req_wdata ((w_req_cmd.op == CMD_WRITE) ? w_req_cmd.data : 32'h0),
        .i_req_write (w_req_cmd.op == CMD_WRITE),
        .o_done      (w_xfer_done),
        .o_rdata     (w_rdata),
        .o_err       (w_xfer_err),
        .o_paddr     (paddr_o),
        .o_pwdata    (pwdata_o),
        .o_pwrite    (pwrite_o),
        .o_psel      (psel_o),
        .o_penable   (penable_o),
        .i_prdata    (prdata_i),
        .i_pready    (pready_i),
        .i_pslverr   (pslverr_i)
    );

    assign busy_o    = (r_state == ST_SETUP) || (r_state == ST_ACCESS) || (r_state == ST_WAIT);
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign err_idx_o = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_clk_cfg_apb_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_cfg_apb_init
// Description : Self-checking bench; acts as the APB responder and walks the
//               command table to predict every bus cycle and status flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_cfg_apb_init;
    import clk_cfg_pkg::*;

    localparam int NUM = 8;
    localparam int PT  = 4;
    localparam cmd_t [NUM-1:0] TB_TABLE = {
        mk_cmd(CMD_POLL,  32'h14, 32'h0000_1200, 32'h0000_FF00),
        mk_cmd(CMD_WRITE, 32'h10, 32'hA5A5_0001, 32'h0),
        mk_cmd(CMD_POLL,  32'h08, 32'h1,         32'h1),
        mk_cmd(CMD_WAIT,  32'h0,  32'd5,         32'h0),
        mk_cmd(CMD_WRITE, 32'h0C, 32'h33,        32'h0),
        mk_cmd(CMD_WAIT,  32'h0,  32'd0,         32'h0),
        mk_cmd(CMD_WRITE, 32'h04, 32'h2,         32'h0),
        mk_cmd(CMD_WRITE, 32'h00, 32'h1,         32'h0)
    };

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, err, pwrite, psel, penable;
    logic        pready, pslverr;
    logic [7:0]  err_idx;
    logic [31:0] paddr, pwdata, prdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    clk_cfg_apb_init #(
        .APB_ADDR_WIDTH (32),
        .NUM_CMDS       (NUM),
        .CMD_TABLE      (TB_TABLE),
        .POLL_TIMEOUT   (PT)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .err_idx_o (err_idx),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .pwrite_o  (pwrite),
        .psel_o    (psel),
        .penable_o (penable),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, ".psel"},    {31'h0, psel},    32'h0);
        chk({tag, ".penable"}, {31'h0, penable}, 32'h0);
        chk({tag, ".paddr"},   paddr,            32'h0);
        chk({tag, ".pwdata"},  pwdata,           32'h0);
        chk({tag, ".pwrite"},  {31'h0, pwrite},  32'h0);
    endtask

    task automatic chk_running(input string tag);
        chk({tag, ".busy"},    {31'h0, busy}, 32'h1);
        chk({tag, ".done"},    {31'h0, done}, 32'h0);
        chk({tag, ".err"},     {31'h0, err},  32'h0);
        chk({tag, ".err_idx"}, {24'h0, err_idx}, 32'h0);
    endtask

    task automatic chk_xfer(input string tag, input cmd_t c, input bit access);
        bit wr;
        wr = (c.op == CMD_WRITE);
        chk({tag, ".psel"},    {31'h0, psel},    32'h1);
        chk({tag, ".penable"}, {31'h0, penable}, {31'h0, access});
        chk({tag, ".paddr"},   paddr,            c.addr);
        chk({tag, ".pwrite"},  {31'h0, pwrite},  {31'h0, wr});
        chk({tag, ".pwdata"},  pwdata,           wr ? c.data : 32'h0);
        chk_running(tag);
    endtask

    // Reference walk of the table: for each entry the bench plays the slave and
    // predicts the exact bus/status sequence. slverr_cmd/fail_poll < 0 disable.
    task automatic run_seq(input int slverr_cmd, input int fail_poll,
                           input int poll_miss, input bit rnd);
        cmd_t        c;
        bit          aborted;
        int          abort_idx, need, misses, ws, n;
        logic [31:0] lowbit, r;
        aborted   = 1'b0;
        abort_idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NUM && !aborted; i++) begin
            c = TB_TABLE[i];
            if (c.op == CMD_WAIT) begin
                n = (c.data == 32'h0) ? 1 : int'(c.data);
                for (int k = 0; k < n; k++) begin
                    chk_running("wait");
                    chk_bus_idle("wait");
                    start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk);
                end
            end else begin
                need   = (i == fail_poll) ? 1000 : (rnd ? int'($urandom_range(0, 3)) : poll_miss);
                misses = 0;
                forever begin
                    chk_xfer("setup", c, 1'b0);
                    pready = 1'b0;
                    prdata = $urandom;
                    start  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk);
                    ws = rnd ? int'($urandom_range(0, 3)) : 0;
                    for (int w = 0; w < ws; w++) begin
                        chk_xfer("access_ws", c, 1'b1);
                        pready = 1'b0;
                        prdata = $urandom;
                        @(negedge clk);
                    end
                    chk_xfer("access", c, 1'b1);
                    pready  = 1'b1;
                    pslverr = (i == slverr_cmd);
                    r       = $urandom;
                    lowbit  = c.mask & (~c.mask + 32'd1);
                    if (c.op == CMD_POLL && misses < need)
                        prdata = ((r & ~c.mask) | (c.data & c.mask)) ^ lowbit;
                    else if (c.op == CMD_POLL)
                        prdata = (r & ~c.mask) | (c.data & c.mask);
                    else
                        prdata = r;
                    @(negedge clk);
                    pready  = 1'b0;
                    pslverr = 1'b0;
                    if (i == slverr_cmd) begin
                        aborted = 1'b1; abort_idx = i; break;
                    end
                    if (c.op == CMD_POLL && misses < need) begin
                        misses++;
                        if (misses == PT) begin
                            aborted = 1'b1; abort_idx = i; break;
                        end
                    end else begin
                        break;
                    end
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("end.busy",    {31'h0, busy},    32'h0);
            chk("end.done",    {31'h0, done},    {31'h0, !aborted});
            chk("end.err",     {31'h0, err},     {31'h0, aborted});
            chk("end.err_idx", {24'h0, err_idx}, aborted ? 32'(abort_idx) : 32'h0);
            chk_bus_idle("end");
            @(negedge clk);
        end
    endtask

    initial begin
        int slv, fp;
        rst_n   = 1'b0;
        start   = 1'b0;
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy",    {31'h0, busy},    32'h0);
        chk("rst.done",    {31'h0, done},    32'h0);
        chk("rst.err",     {31'h0, err},     32'h0);
        chk("rst.err_idx", {24'h0, err_idx}, 32'h0);
        chk_bus_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_bus_idle("post_rst");

        // Zero-wait slave, polls returning 0,0,1 before matching.
        run_seq(-1, -1, 2, 1'b0);
        // Slave error on the second write, then a clean restart.
        run_seq(1, -1, 0, 1'b0);
        run_seq(-1, -1, 0, 1'b0);
        // POLL at index 5 never matches.
        run_seq(-1, 5, 0, 1'b0);
        // Slave error on a poll read.
        run_seq(7, -1, 1, 1'b1);

        for (int r = 0; r < 12; r++) begin
            slv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM - 1)) : -1;
            fp  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 5 : 7) : -1;
            run_seq(slv, fp, 0, 1'b1);
        end

        // Reset asserted during ACCESS drops the bus asynchronously.
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pready = 1'b0;
        @(negedge clk);
        chk("pre_rst.penable", {31'h0, penable}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.busy", {31'h0, busy}, 32'h0);
        chk("async_rst.done", {31'h0, done}, 32'h0);
        chk("async_rst.err",  {31'h0, err},  32'h0);
        chk_bus_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bus_idle("rst_idle");
        chk("rst_idle.busy", {31'h0, busy}, 32'h0);
        run_seq(-1, -1, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
